// File: rtl/sliding_window_hop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sliding_window_hop
//  Description : Circular-buffer window extractor. Every accepted sample is
//                stored; every H-th accepted sample emits the L most recent
//                samples (oldest first) as one AXI-Stream packet through a
//                registered-read RAM and a 2-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_hop #(
    parameter  int PAR_DATA_WIDTH = 16,
    parameter  int PAR_MAX_LEN    = 128,
    parameter  int PAR_HOP_WIDTH  = 8,
    localparam int PAR_IDX_WIDTH  = $clog2(PAR_MAX_LEN)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PAR_IDX_WIDTH:0]    i_win_len,
    input  logic [PAR_HOP_WIDTH-1:0]  i_hop,
    input  logic                      s_axis_tvalid,
    input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [PAR_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [PAR_IDX_WIDTH-1:0]  m_axis_tuser
);

    localparam int DW = PAR_DATA_WIDTH;
    localparam int IW = PAR_IDX_WIDTH;
    localparam int HW = PAR_HOP_WIDTH;

    localparam logic [1:0]    c_ST_CLEAR  = 2'd0;
    localparam logic [1:0]    c_ST_IDLE   = 2'd1;
    localparam logic [1:0]    c_ST_EMIT   = 2'd2;
    localparam logic [IW:0]   c_MAX_LEN   = (IW+1)'(PAR_MAX_LEN);
    localparam logic [IW-1:0] c_LAST_ADDR = IW'(PAR_MAX_LEN - 1);

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       clr_cnt_q, wr_ptr_q, rd_ptr_q;
    logic [HW-1:0]       hop_cnt_q;
    logic [IW:0]         len_q, issued_q;

    // Read pipeline stage (aligned with the registered RAM output)
    logic                rd_vld_q;
    logic [IW-1:0]       rd_idx_q;
    logic                rd_last_q;
    logic [DW-1:0]       rd_data_q;

    // Two-entry skid buffer, head_q points at the beat on the output
    logic [1:0][DW-1:0]  ent_data_q;
    logic [1:0][IW-1:0]  ent_idx_q;
    logic [1:0]          ent_last_q;
    logic [1:0]          cnt_q;
    logic                head_q;

    logic [DW-1:0]       ram_q [PAR_MAX_LEN];

    logic                w_accept, w_trig, w_pop, w_rd_en, w_out_last, w_tail, w_we;
    logic [IW:0]         w_len_eff;
    logic [HW-1:0]       w_hop_eff;
    logic [HW:0]         w_hop_next;
    logic [2:0]          w_occ;
    logic [IW-1:0]       w_rd_addr, w_waddr;
    logic [DW-1:0]       w_wdata;

    // Clamp runtime configuration and derive handshake / read-issue controls
    always_comb begin
        if (i_win_len == '0) begin
            w_len_eff = (IW+1)'(1);
        end else if (i_win_len > c_MAX_LEN) begin
            w_len_eff = c_MAX_LEN;
        end else begin
            w_len_eff = i_win_len;
        end
        w_hop_eff  = (i_hop == '0) ? HW'(1) : i_hop;
        w_hop_next = {1'b0, hop_cnt_q} + (HW+1)'(1);
        w_accept   = s_axis_tvalid && s_axis_tready;
        w_trig     = w_hop_next >= {1'b0, w_hop_eff};
        w_pop      = m_axis_tvalid && m_axis_tready;
        w_out_last = ent_last_q[head_q];
        w_tail     = head_q ^ cnt_q[0];
        // A beat leaving this cycle frees a slot, which keeps 1 beat/cycle
        w_occ      = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, w_pop};
        w_rd_en    = (state_q == c_ST_EMIT) && (issued_q < len_q) && (w_occ < 3'd2);
        w_rd_addr  = rd_ptr_q + issued_q[IW-1:0];
        w_we       = !i_rst && ((state_q == c_ST_CLEAR) || w_accept);
        w_waddr    = (state_q == c_ST_CLEAR) ? clr_cnt_q : wr_ptr_q;
        w_wdata    = (state_q == c_ST_CLEAR) ? '0 : s_axis_tdata;
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= c_ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_CLEAR: if (clr_cnt_q == c_LAST_ADDR) state_d = c_ST_IDLE;
            c_ST_IDLE:  if (w_accept && w_trig)       state_d = c_ST_EMIT;
            c_ST_EMIT:  if (w_pop && w_out_last)      state_d = c_ST_IDLE;
            default:                                  state_d = c_ST_CLEAR;
        endcase
    end

    // FSM and skid-buffer driven outputs
    always_comb begin
        s_axis_tready = (state_q == c_ST_IDLE);
        m_axis_tvalid = (cnt_q != 2'd0);
        m_axis_tdata  = ent_data_q[head_q];
        m_axis_tuser  = ent_idx_q[head_q];
        m_axis_tlast  = w_out_last;
    end

    // Sample buffer: one write port, registered read port, no reset
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            ram_q[w_waddr] <= w_wdata;
        end
        if (w_rd_en) begin
            rd_data_q <= ram_q[w_rd_addr];
        end
    end

    // Pointers, hop counter, window read sequencing and skid buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hop_cnt_q  <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
            ent_data_q <= '0;
            ent_idx_q  <= '0;
            ent_last_q <= '0;
            cnt_q      <= '0;
            head_q     <= 1'b0;
        end else begin
            if (state_q == c_ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + IW'(1);
            end
            if (w_accept) begin
                wr_ptr_q <= wr_ptr_q + IW'(1);
                if (w_trig) begin
                    hop_cnt_q <= '0;
                    len_q     <= w_len_eff;
                    issued_q  <= '0;
                    // Oldest sample of the window; truncation gives the wrap
                    rd_ptr_q  <= wr_ptr_q + IW'(1) - w_len_eff[IW-1:0];
                end else begin
                    hop_cnt_q <= w_hop_next[HW-1:0];
                end
            end
            if (w_rd_en) begin
                issued_q <= issued_q + (IW+1)'(1);
            end
            rd_vld_q  <= w_rd_en;
            rd_idx_q  <= issued_q[IW-1:0];
            rd_last_q <= (issued_q == len_q - (IW+1)'(1));
            if (rd_vld_q) begin
                ent_data_q[w_tail] <= rd_data_q;
                ent_idx_q[w_tail]  <= rd_idx_q;
                ent_last_q[w_tail] <= rd_last_q;
            end
            if (w_pop) begin
                head_q <= ~head_q;
            end
            cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
